// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative RV32M multiply/divide unit for the EX stage.
//
// Takes a decoded M-op from the ID/EX register and holds the instruction in
// EX (MulDivBusyE) until the result is ready. It then presents the result and
// Rd for exactly one cycle (MulDivDoneE) so that the EX/MEM register captures it.
//
// Ports:
//   CLK            rising-edge clock
//   RSTn           synchronous active-low reset
//   StartE         valid M-extension instruction present in EX
//   MulDivOpE      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcAE / SrcBE  rs1 / rs2 after forwarding (sampled only at start)
//   RdE            destination register of the EX instruction
//   KillE          flush: abandon the current operation, no Done pulse
//   MulDivBusyE    stall request to the hazard unit
//   MulDivDoneE    result valid this cycle
//   MulDivResultE  result (0 when not done)
//   MulDivRdE      Rd latched at start (0 when idle)
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, MUL-class ops use a single-cycle 33x33 signed multiply and
//   finish one cycle after start. When undefined, a 32-cycle shift-add
//   multiplier is used and no multiplier array is inferred.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  input  logic            KillE,
  output logic            MulDivBusyE,
  output logic            MulDivDoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic [4:0]      MulDivRdE
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0]   ONE_W   = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_D   = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [4:0]        LAST_IT = 5'd31;

  function automatic logic [XLEN-1:0] negate_w(input logic [XLEN-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_d(input logic [2*XLEN-1:0] x);
    return ~x + ONE_D;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;        // {hi, lo}: product or {remainder, quotient}
  logic              neg_q, neg_d;        // product / quotient sign
  logic              rneg_q, rneg_d;      // remainder sign (dividend sign)
  logic [XLEN-1:0]   result_q, result_d;

  // Start decode: signedness, magnitudes and the special division cases
  logic            a_signed, b_signed, sa, sb;
  logic            div_by_zero, div_ovf, start_ok, is_div;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed    = (MulDivOpE == 3'd1) || (MulDivOpE == 3'd2) ||
                  (MulDivOpE == 3'd4) || (MulDivOpE == 3'd6);
    b_signed    = (MulDivOpE == 3'd1) || (MulDivOpE == 3'd4) || (MulDivOpE == 3'd6);
    sa          = a_signed & SrcAE[XLEN-1];
    sb          = b_signed & SrcBE[XLEN-1];
    a_mag       = sa ? negate_w(SrcAE) : SrcAE;
    b_mag       = sb ? negate_w(SrcBE) : SrcBE;
    is_div      = MulDivOpE[2];
    div_by_zero = (SrcBE == '0);
    div_ovf     = ((MulDivOpE == 3'd4) || (MulDivOpE == 3'd6)) &&
                  (SrcAE == INT_MIN) && (SrcBE == '1);
    start_ok    = StartE & ~KillE;
  end

  // One iteration of shift-add multiply / restoring divide
  logic [XLEN:0]     mul_sum, div_sh;
  logic [2*XLEN-1:0] mul_next, mul_fixed, div_next;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub, quo_next, rem_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    mul_fixed = neg_q ? negate_d(mul_next) : mul_next;
    // Remainder shifted left with the next dividend bit; always < 2*divisor.
    div_sh    = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = (div_sh >= {1'b0, mcand_q});
    div_sub   = div_sh[XLEN-1:0] - mcand_q;
    div_next  = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                       : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    quo_next  = div_next[XLEN-1:0];
    rem_next  = div_next[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_FAST_MUL_EN
  // The extra top bit carries the operand sign, so one signed multiply
  // covers all four MUL-class signedness combinations.
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_prod = $signed({sa, SrcAE}) * $signed({sb, SrcBE});
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d     = MulDivOpE;
          rd_d     = RdE;
          cnt_d    = '0;
          mcand_d  = b_mag;
          acc_d    = {{XLEN{1'b0}}, a_mag};
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          result_d = '0;
          if (is_div) begin
            if (div_by_zero) begin
              result_d = MulDivOpE[1] ? SrcAE : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = MulDivOpE[1] ? '0 : INT_MIN;
              state_d  = S_DONE;
            end else begin
              state_d  = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = (MulDivOpE == 3'd0) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`else
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_IT) begin
          result_d = (op_q == 3'd0) ? mul_fixed[XLEN-1:0] : mul_fixed[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_IT) begin
          if (op_q[1]) result_d = rneg_q ? negate_w(rem_next) : rem_next;
          else         result_d = neg_q  ? negate_w(quo_next) : quo_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // StartE is still high from the same instruction; never restart here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (KillE) state_d = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign MulDivBusyE   = ((state_q == S_IDLE) & start_ok) | (state_q == S_MUL) | (state_q == S_DIV);
  assign MulDivDoneE   = (state_q == S_DONE);
  assign MulDivResultE = MulDivDoneE ? result_q : '0;
  assign MulDivRdE     = (state_q != S_IDLE) ? rd_q : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        KillE;
  logic        MulDivBusyE, MulDivDoneE;
  logic [31:0] MulDivResultE;
  logic [4:0]  MulDivRdE;

  always #5 CLK = ~CLK;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .StartE(StartE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .KillE(KillE),
    .MulDivBusyE(MulDivBusyE), .MulDivDoneE(MulDivDoneE),
    .MulDivResultE(MulDivResultE), .MulDivRdE(MulDivRdE)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;
  localparam int LAT_SPC = 1;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'b0, MulDivBusyE}, 32'd0);
    check({tag, "_done"}, {31'b0, MulDivDoneE}, 32'd0);
    check({tag, "_res"},  MulDivResultE, 32'd0);
    check({tag, "_rd"},   {27'b0, MulDivRdE}, 32'd0);
  endtask

  // Issue one instruction in the current (idle) cycle, hold StartE through
  // DONE like a stalled pipeline, scribble on the operands meanwhile, and
  // leave the bench at the negedge of the following idle cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] res, input int lat);
    exp_t e;
    int   k;
    bit   done;
    MulDivOpE = op; SrcAE = a; SrcBE = b; RdE = rd; StartE = 1'b1; KillE = 1'b0;
    sb_q.push_back({res, rd, 32'(lat)});
    #1;
    check({tag, "_busyT"}, {31'b0, MulDivBusyE}, 32'd1);
    k = 0; done = 1'b0;
    while (!done && k < 60) begin
      @(negedge CLK);
      k++;
      SrcAE = $urandom; SrcBE = $urandom; RdE = 5'($urandom);
      #1;
      if (MulDivDoneE) done = 1'b1;
      else check({tag, "_busy_wait"}, {31'b0, MulDivBusyE}, 32'd1);
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, 32'(k), e.lat);
    check({tag, "_result"}, MulDivResultE, e.res);
    check({tag, "_rd"}, {27'b0, MulDivRdE}, {27'b0, e.rd});
    check({tag, "_busy_done"}, {31'b0, MulDivBusyE}, 32'd0);
    @(negedge CLK);
    StartE = 1'b0;
    #1;
    check({tag, "_after_done"}, {31'b0, MulDivDoneE}, 32'd0);
    check({tag, "_no_restart"}, {31'b0, MulDivBusyE}, 32'd0);
  endtask

  initial begin
    RSTn = 1'b0; StartE = 1'b0; KillE = 1'b0; MulDivOpE = 3'd0;
    SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle("idle_nostart");

    // Multiply class
    run_op("mul_7x6",      3'd0, 32'd7,        32'd6,        5'd5,  32'd42,        LAT_MUL);
    run_op("mul_neg",      3'd0, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1,  LAT_MUL);
    run_op("mulh_m1m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000,  LAT_MUL);
    run_op("mulhu_m1m1",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE,  LAT_MUL);
    run_op("mulhsu_m1_2",  3'd2, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF,  LAT_MUL);
    run_op("mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000,  LAT_MUL);

    // Divide class
    run_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD,  LAT_DIV);
    run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF,  LAT_DIV);
    run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        5'd10, 32'd14,        LAT_DIV);
    run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        5'd11, 32'd2,         LAT_DIV);
    run_op("div_7_m2",     3'd4, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD,  LAT_DIV);
    run_op("rem_7_m2",     3'd6, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,         LAT_DIV);
    run_op("divu_min_m1",  3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,         LAT_DIV);
    run_op("remu_min_m1",  3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000,  LAT_DIV);

    // Special cases resolved at start
    run_op("div_5_0",      3'd4, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF,  LAT_SPC);
    run_op("remu_5_0",     3'd7, 32'd5,        32'd0,        5'd17, 32'd5,         LAT_SPC);
    run_op("divu_5_0",     3'd5, 32'd5,        32'd0,        5'd18, 32'hFFFFFFFF,  LAT_SPC);
    run_op("rem_m5_0",     3'd6, 32'hFFFFFFFB, 32'd0,        5'd19, 32'hFFFFFFFB,  LAT_SPC);
    run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000,  LAT_SPC);
    run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'd0,         LAT_SPC);

    // Kill together with start in IDLE: nothing starts
    MulDivOpE = 3'd4; SrcAE = 32'd9; SrcBE = 32'd3; RdE = 5'd22; StartE = 1'b1; KillE = 1'b1;
    #1;
    check("kill_at_start_busy", {31'b0, MulDivBusyE}, 32'd0);
    @(negedge CLK);
    StartE = 1'b0; KillE = 1'b0;
    #1;
    check_idle("kill_at_start");

    // Kill a running DIV at T+10; the next op starts at T+11
    MulDivOpE = 3'd4; SrcAE = 32'd100; SrcBE = 32'd7; RdE = 5'd23; StartE = 1'b1; KillE = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      #1;
      check("kill_div_no_done", {31'b0, MulDivDoneE}, 32'd0);
    end
    KillE = 1'b1;
    @(negedge CLK);
    StartE = 1'b0; KillE = 1'b0;
    #1;
    check_idle("kill_div");
    run_op("remu_9_4_after_kill", 3'd7, 32'd9, 32'd4, 5'd9, 32'd1, LAT_DIV);

    // Reset in the middle of a MUL
    MulDivOpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd3; RdE = 5'd24; StartE = 1'b1; KillE = 1'b0;
    repeat (5) @(negedge CLK);
    RSTn = 1'b0; StartE = 1'b0;
    @(negedge CLK);
    #1;
    check_idle("reset_mid_mul");
    RSTn = 1'b1;
    @(negedge CLK);
    #1;
    check_idle("after_reset_mid_mul");

    // Back-to-back MUL then DIV, StartE held through each DONE
    run_op("b2b_mul",      3'd0, 32'd12,       32'd11,       5'd25, 32'd132,       LAT_MUL);
    run_op("b2b_div",      3'd4, 32'd132,      32'd11,       5'd26, 32'd12,        LAT_DIV);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
